uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer: start/data/stop sequencing on external mid-bit ticks
module uart_rx_framer #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 center_tick,
    output logic                 phase_arm,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    logic                 fall;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CW-1:0]        bit_cnt;

    // Line idles high, so the synchronizer resets to 1 to avoid a fake start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            phase_arm   <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            phase_arm   <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            if (data_valid && data_ready)
                data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        phase_arm <= 1'b1;
                        state     <= START;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (center_tick) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (center_tick) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(DATA_BITS - 1))
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (center_tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (!data_valid || data_ready) begin
                            // A same-edge consume frees the buffer, so the new byte wins.
                            data       <= shift_reg;
                            data_valid <= 1'b1;
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
